// File: rtl/fsm_step_pkg.sv
// Shared constants and controller state encoding for the step controller.
// No ports; imported by seq_mem and fsm_step_ctrl.
package fsm_step_pkg;

  localparam int SEQ_DEPTH = 16;
  localparam int AW        = 4;
  localparam int SW_W      = 2;
  localparam int ST_W      = 3;
  localparam int LEN_W     = 5;

  localparam logic [LEN_W-1:0] MAX_LEN = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_CAPT,
    S_EMIT,
    S_FIN
  } ctrl_state_t;

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] len
  );
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/seq_mem.sv
// Input-sequence store: DEPTH x 2-bit, one write port, one async read.
// Ports: clk, we/waddr/wdata write, raddr -> rdata read. No reset.
module seq_mem
  import fsm_step_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [SW_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [SW_W-1:0] rdata
);

  logic [SW_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_step_ctrl.sv
// Steps an external Moore FSM through a stored sw_in sequence and
// streams (idx,state,out) per step over a valid/ready result channel.
// Ports: clk, reset (sync, active-low); prog_* memory write;
// start/init_state/seq_len run request; dut_* drive/sample the FSM;
// res_* result channel; busy/done status.
module fsm_step_ctrl
  import fsm_step_pkg::ctrl_state_t,
         fsm_step_pkg::S_IDLE,
         fsm_step_pkg::S_LOAD,
         fsm_step_pkg::S_STEP,
         fsm_step_pkg::S_CAPT,
         fsm_step_pkg::S_EMIT,
         fsm_step_pkg::S_FIN,
         fsm_step_pkg::AW,
         fsm_step_pkg::SW_W,
         fsm_step_pkg::ST_W,
         fsm_step_pkg::LEN_W,
         fsm_step_pkg::clamp_len;
#(
  parameter int SEQ_DEPTH = fsm_step_pkg::SEQ_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [SW_W-1:0]  prog_data,
  input  logic             start,
  input  logic [ST_W-1:0]  init_state,
  input  logic [LEN_W-1:0] seq_len,
  output logic             dut_reset,
  output logic [ST_W-1:0]  dut_state_in,
  output logic [SW_W-1:0]  dut_sw_in,
  output logic             dut_ctrl,
  input  logic [ST_W-1:0]  dut_state,
  input  logic             dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AW-1:0]    res_idx,
  output logic [ST_W-1:0]  res_state,
  output logic             res_out,
  output logic             busy,
  output logic             done
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;

  logic [ST_W-1:0]  init_q;
  logic [LEN_W-1:0] len_q;
  logic [AW-1:0]    idx_q;
  logic [SW_W-1:0]  sw_q;
  logic [AW-1:0]    ridx_q;
  logic [ST_W-1:0]  rstate_q;
  logic             rout_q;
  logic [SW_W-1:0]  mem_rd;

  logic idle;
  logic mem_we;
  logic hs;
  logic more;

  assign idle   = (state_q == S_IDLE);
  assign mem_we = prog_we & reset & idle;
  assign hs     = (state_q == S_EMIT) & res_ready;
  // idx+1 compared in the length width so 16 steps fit
  assign more   = ({1'b0, idx_q} + 5'd1) < len_q;

  seq_mem #(
    .DEPTH (SEQ_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (idx_q),
    .rdata (mem_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      init_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      sw_q     <= '0;
      ridx_q   <= '0;
      rstate_q <= '0;
      rout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idle && start) begin
        init_q <= init_state;
        len_q  <= clamp_len(seq_len);
        idx_q  <= '0;
      end
      // sw_in stays at the last stepped value between steps
      if (state_q == S_STEP) begin
        sw_q <= mem_rd;
      end
      if (state_q == S_CAPT) begin
        ridx_q   <= idx_q;
        rstate_q <= dut_state;
        rout_q   <= dut_out;
      end
      if (hs) begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        state_d = (len_q != '0) ? S_STEP : S_FIN;
      end
      S_STEP: state_d = S_CAPT;
      S_CAPT: state_d = S_EMIT;
      S_EMIT: begin
        if (res_ready) begin
          state_d = more ? S_STEP : S_FIN;
        end
      end
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dut_reset    = 1'b0;
    dut_state_in = '0;
    dut_ctrl     = 1'b0;
    dut_sw_in    = sw_q;
    res_valid    = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    unique case (1'b1)
      (state_q == S_IDLE): busy = 1'b0;
      (state_q == S_LOAD): begin
        dut_reset    = 1'b1;
        dut_state_in = init_q;
      end
      (state_q == S_STEP): begin
        dut_ctrl  = 1'b1;
        dut_sw_in = mem_rd;
      end
      (state_q == S_EMIT): res_valid = 1'b1;
      (state_q == S_FIN):  done = 1'b1;
      default: ;
    endcase
  end

  assign res_idx   = ridx_q;
  assign res_state = rstate_q;
  assign res_out   = rout_q;

endmodule
